// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared encodings for the pipeline hazard controller and forwarding.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lu_detect.sv
`default_nettype none
// ============================================================================
// Module   : lu_detect
// Purpose  : Combinational load-use comparator between the EXE and ID stages.
// Revision : 1.0 - initial release
// ============================================================================
module lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic                  exe_wr_en,
    input  logic                  exe_is_load,
    input  logic [REG_ADDR_W-1:0] id_rsA_addr,
    input  logic [REG_ADDR_W-1:0] id_rsB_addr,
    input  logic                  id_uses_rsA,
    input  logic                  id_uses_rsB,
    output logic                  lu
);

    logic match_a;
    logic match_b;

    assign match_a = id_uses_rsA && (id_rsA_addr == exe_rd);
    assign match_b = id_uses_rsB && (id_rsB_addr == exe_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign lu = exe_is_load && exe_wr_en && (exe_rd != REG_X0) && (match_a || match_b);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline; optional stall
//            counter enabled by defining PIPE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rsA_addr,
    input  logic [REG_ADDR_W-1:0] id_rsB_addr,
    input  logic                  id_uses_rsA,
    input  logic                  id_uses_rsB,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic                  exe_wr_en,
    input  logic                  exe_is_load,
    input  logic                  exe_is_div,
    input  logic                  exe_br_taken,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_exe_en,
    output logic                  id_exe_flush,
    output logic                  exe_mem_en,
    output logic                  exe_mem_flush,
    output logic                  mem_wb_en,
    output logic                  div_start,
    output logic                  div_busy,
    output logic [31:0]           stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lu;
    logic             stall;
    logic             hazard_en;

    lu_detect u_lu_detect (
        .exe_rd      (exe_rd),
        .exe_wr_en   (exe_wr_en),
        .exe_is_load (exe_is_load),
        .id_rsA_addr (id_rsA_addr),
        .id_rsB_addr (id_rsB_addr),
        .id_uses_rsA (id_uses_rsA),
        .id_uses_rsB (id_uses_rsB),
        .lu          (lu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        hazard_en = 1'b0;
        div_start = 1'b0;
        div_busy  = 1'b0;
        case (state)
            RUN: begin
                // A divide on the wrong path of a taken branch must not start
                if (exe_is_div && !exe_br_taken) begin
                    div_start = 1'b1;
                    div_busy  = 1'b1;
                    stall     = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = DIV_BUSY;
                end else begin
                    hazard_en = 1'b1;
                end
            end
            DIV_BUSY: begin
                stall    = 1'b1;
                div_busy = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // exe_is_div is deliberately ignored: the divide is still in EXE
                hazard_en = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_en     = 1'b1;
        id_exe_flush  = 1'b0;
        exe_mem_en    = 1'b1;
        exe_mem_flush = 1'b0;
        mem_wb_en     = 1'b1;

        if (stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
        end else if (hazard_en) begin
            if (exe_br_taken) begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (lu) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_exe_flush = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b0;
            id_exe_en     = 1'b0;
            id_exe_flush  = 1'b0;
            exe_mem_en    = 1'b0;
            exe_mem_flush = 1'b0;
            mem_wb_en     = 1'b0;
            div_start     = 1'b0;
            div_busy      = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (!pc_en && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign stall_cycles = rst ? 32'd0 : perf_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32IMC pipeline.
- Generates per-stage enable and flush strobes for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch and jump redirects, and multi-cycle divide occupancy of EXE.
- Flush strobes are ORed into the target register's clear term at integration, producing an all-zero bubble.

Parameters:
DIV_CYCLES, 32, total cycles a DIV/DIVU/REM/REMU instruction stalls upstream stages; legal range 2..255.
CNT_W, 8, width of the internal divide countdown counter; must hold DIV_CYCLES-2.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_rsA_addr  in  5  ID-stage source register A
id_rsB_addr  in  5  ID-stage source register B
id_uses_rsA  in  1  ID instruction reads rsA
id_uses_rsB  in  1  ID instruction reads rsB
id_jump  in  1  JAL resolved in ID
exe_rd  in  5  EXE-stage destination register
exe_wr_en  in  1  EXE instruction writes regfile
exe_is_load  in  1  EXE instruction is a load
exe_is_div  in  1  EXE instruction is a divide/remainder op
exe_br_taken  in  1  taken branch or JALR resolved in EXE
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID clear
id_exe_en  out  1  ID/EXE register enable
id_exe_flush  out  1  ID/EXE clear
exe_mem_en  out  1  EXE/MEM register enable
exe_mem_flush  out  1  EXE/MEM clear
mem_wb_en  out  1  MEM/WB register enable
div_start  out  1  one-cycle pulse that starts the divider
div_busy  out  1  divide occupying EXE
stall_cycles  out  32  cumulative stall-cycle count (see Optional Feature)

Behaviour:
- Reset (one clock, synchronous, active-high rst):
  - State goes to RUN and the counter to 0.
  - While rst is high, every output is forced to 0.
  - A reset during DIV_BUSY or DIV_DONE aborts the divide without a div_start retrigger.
- Outputs are combinational from state and inputs. Defaults: all *_en=1, all flush=0, div_start=0, div_busy=0.
- Load-use hazard (lu):
  - Condition: exe_is_load & exe_wr_en & exe_rd!=0 & ((id_uses_rsA & id_rsA_addr==exe_rd) | (id_uses_rsB & id_rsB_addr==exe_rd)).
  - Response: pc_en=0, if_id_en=0, id_exe_flush=1. Exactly one bubble; no state is required.
- exe_br_taken: if_id_flush=1, id_exe_flush=1, pc_en=1.
- id_jump: if_id_flush=1, pc_en=1.
- Priority (highest first): divide FSM stall > exe_br_taken > lu > id_jump. exe_br_taken cancels lu because the ID instruction is wrong-path.
- FSM states: RUN, DIV_BUSY, DIV_DONE.
- RUN:
  - If exe_is_div & !exe_br_taken: div_start=1, div_busy=1, stall asserted, cnt<=DIV_CYCLES-2, next state DIV_BUSY.
  - Otherwise apply the hazard logic above.
- DIV_BUSY: stall asserted, div_busy=1. If cnt!=0, cnt<=cnt-1; if cnt==0, next state DIV_DONE.
- DIV_DONE:
  - Release cycle: normal hazard logic applies, but exe_is_div is ignored, so the same instruction does not retrigger.
  - div_busy=0; next state RUN.
  - A back-to-back divide arriving in EXE on the following cycle starts normally from RUN.
- "Stall asserted" means pc_en=0, if_id_en=0, id_exe_en=0, exe_mem_flush=1; mem_wb_en stays 1 so older instructions drain.
- A divide occupies EXE for exactly DIV_CYCLES+1 cycles: DIV_CYCLES stalled cycles plus one release cycle.
- exe_mem_en is deasserted only during reset. Stalls always insert a bubble into EXE/MEM rather than freezing it.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined: stall_cycles increments by 1 on every cycle with pc_en==0 and rst==0. It saturates at 0xFFFFFFFF and is cleared by rst.
- Undefined: stall_cycles is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding constants: RUN=2'd0, DIV_BUSY=2'd1, DIV_DONE=2'd2.
  - Register-address width (5) and the x0 constant.
- Sub-module lu_detect: purely combinational load-use comparator producing lu. It is reusable by the forwarding unit.

Test Plan:
1. Load-use: `lw x5` in EXE (exe_rd=5, exe_is_load=1, exe_wr_en=1) with ID `add` using rsA=5 -> one cycle of pc_en=0, if_id_en=0, id_exe_flush=1. With exe_rd=0 -> no stall.
2. Branch beats load-use: lu condition and exe_br_taken=1 in the same cycle -> if_id_flush=1, id_exe_flush=1, pc_en=1, no stall.
3. Divide with DIV_CYCLES=4: exe_is_div rises at cycle t -> div_start high only at t; stall at t..t+3; release at t+4 with all enables 1 and exe_mem_flush=0; no second div_start while exe_is_div stays high at t+4.
4. Back-to-back divides: second divide enters EXE at t+5 -> div_start at t+5 and a new 4-cycle stall.
5. Reset mid-divide: rst=1 at t+2 -> all outputs 0 that cycle; at t+3 with rst=0 and exe_is_div=0 -> RUN defaults, div_busy=0.
6. PIPE_PERF_CNT_EN defined: run scenario 1 then scenario 3 -> stall_cycles=5. Undefined -> stall_cycles stays 0.
